// File: rtl/uart_tx_port.sv
// Console output port that snoops data-memory writes to TX_ADDR and sends each
// 16-bit word as two 8N1 UART frames, low byte first, through a small word FIFO.
module uart_tx_port #(
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [9:0]  TX_ADDR      = 10'h3FF,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [9:0]                   wr_addr,
  input  logic [15:0]                  wr_data,
  output logic                         tx,
  output logic                         busy,
  output logic                         fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         overflow
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [2:0]          bit_idx_q, bit_idx_d;
  logic                byte_sel_q, byte_sel_d;
  logic [15:0]         hold_q, hold_d;
  logic                tx_q, tx_d;
  logic [PTR_W-1:0]    head_q, head_d;
  logic [PTR_W-1:0]    tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                ovf_q, ovf_d;
  logic [15:0]         mem_q [FIFO_DEPTH];

  logic                push_req;
  logic                full;
  logic                push_ok;
  logic                pop;
  logic                has_word;
  logic                baud_done;
  logic [7:0]          cur_byte;

  // Fullness uses the pre-edge count, so a same-edge pop never makes room for a push.
  assign push_req  = wr_en && (wr_addr == TX_ADDR);
  assign full      = (count_q == DEPTH_C);
  assign push_ok   = push_req && !full;
  assign has_word  = (count_q != '0);
  assign baud_done = (baud_q == BAUD_LAST);
  assign cur_byte  = byte_sel_q ? hold_q[15:8] : hold_q[7:0];

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    byte_sel_d = byte_sel_q;
    hold_d     = hold_q;
    tx_d       = tx_q;
    pop        = 1'b0;

    if (state_q != S_IDLE) begin
      baud_d = baud_done ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (has_word) begin
          pop        = 1'b1;
          state_d    = S_START;
          byte_sel_d = 1'b0;
          baud_d     = '0;
          tx_d       = 1'b0;
        end
      end
      S_START: begin
        if (baud_done) begin
          state_d   = S_DATA;
          bit_idx_d = 3'd0;
          tx_d      = cur_byte[0];
        end
      end
      S_DATA: begin
        if (baud_done) begin
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = cur_byte[bit_idx_d];
          end
        end
      end
      S_STOP: begin
        if (baud_done) begin
          if (!byte_sel_q) begin
            state_d    = S_START;
            byte_sel_d = 1'b1;
            tx_d       = 1'b0;
          end else if (has_word) begin
            // Back-to-back words: the next start bit follows this stop bit directly.
            pop        = 1'b1;
            state_d    = S_START;
            byte_sel_d = 1'b0;
            tx_d       = 1'b0;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    if (pop) begin
      hold_d = mem_q[head_q];
    end
  end

  always_comb begin
    head_d  = pop ? head_q + 1'b1 : head_q;
    tail_d  = push_ok ? tail_q + 1'b1 : tail_q;
    ovf_d   = ovf_q || (push_req && full);
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= 3'd0;
      byte_sel_q <= 1'b0;
      tx_q       <= 1'b1;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      byte_sel_q <= byte_sel_d;
      tx_q       <= tx_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end

  // Storage carries data only; the pointers and count decide what is valid.
  always_ff @(posedge clk) begin
    hold_q <= hold_d;
    if (push_ok) begin
      mem_q[tail_q] <= wr_data;
    end
  end

  assign tx         = tx_q;
  assign busy       = (state_q != S_IDLE);
  assign fifo_full  = full;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_uart_tx_port.sv
// Directed bench for uart_tx_port: one instance at 4 clocks/bit, one at 2 clocks/bit.
module tb_uart_tx_port;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        wr_en;
  logic        target;
  logic [9:0]  wr_addr;
  logic [15:0] wr_data;
  logic        wr_en_a, wr_en_b;
  logic        tx_a, busy_a, full_a, ovf_a;
  logic        tx_b, busy_b, full_b, ovf_b;
  logic [3:0]  cnt_a, cnt_b;
  logic        tx_s, busy_s, full_s, ovf_s;
  logic [3:0]  cnt_s;

  int checks = 0;
  int errors = 0;

  assign wr_en_a = wr_en & ~target;
  assign wr_en_b = wr_en & target;
  assign tx_s    = target ? tx_b   : tx_a;
  assign busy_s  = target ? busy_b : busy_a;
  assign full_s  = target ? full_b : full_a;
  assign ovf_s   = target ? ovf_b  : ovf_a;
  assign cnt_s   = target ? cnt_b  : cnt_a;

  uart_tx_port #(.CLKS_PER_BIT(4), .TX_ADDR(10'h3FF), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en_a), .wr_addr(wr_addr), .wr_data(wr_data),
    .tx(tx_a), .busy(busy_a), .fifo_full(full_a), .fifo_count(cnt_a), .overflow(ovf_a)
  );

  uart_tx_port #(.CLKS_PER_BIT(2), .TX_ADDR(10'h3FF), .FIFO_DEPTH(8)) dut2 (
    .clk(clk), .rst(rst), .wr_en(wr_en_b), .wr_addr(wr_addr), .wr_data(wr_data),
    .tx(tx_b), .busy(busy_b), .fifo_full(full_b), .fifo_count(cnt_b), .overflow(ovf_b)
  );

  typedef struct {
    logic        tgt;
    logic [9:0]  addr;
    logic [15:0] data;
    logic        sent;
    logic [19:0] bits;   // bits[0] is the first bit on the line
  } frame_vec_t;

  frame_vec_t frames[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [9:0] a, input logic [15:0] d);
    wr_addr = a;
    wr_data = d;
    wr_en   = 1'b1;
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
  endtask

  task automatic do_reset();
    wr_en = 1'b0;
    rst   = 1'b1;
    tick(1);
    rst   = 1'b0;
  endtask

  task automatic check_idle(input string tag, input logic exp_ovf);
    chk({tag, "_tx"},    tx_s,   1);
    chk({tag, "_busy"},  busy_s, 0);
    chk({tag, "_count"}, cnt_s,  0);
    chk({tag, "_full"},  full_s, 0);
    chk({tag, "_ovf"},   ovf_s,  exp_ovf);
  endtask

  function automatic logic frame_bit(input logic [15:0] d, input int k);
    if (k == 0 || k == 10) return 1'b0;
    if (k == 9 || k == 19) return 1'b1;
    if (k < 9) return d[k-1];
    return d[k-3];
  endfunction

  task automatic run_frame(input int idx, input frame_vec_t v);
    int cpb;
    cpb    = v.tgt ? 2 : 4;
    target = v.tgt;
    do_reset();
    push(v.addr, v.data);
    @(posedge clk);
    for (int k = 0; k < 20; k++) begin
      for (int c = 0; c < cpb; c++) begin
        @(negedge clk);
        chk($sformatf("frame%0d_tx_bit%0d", idx, k), tx_s, v.sent ? v.bits[k] : 1'b1);
        chk($sformatf("frame%0d_busy_bit%0d", idx, k), busy_s, v.sent);
      end
    end
    @(negedge clk);
    check_idle($sformatf("frame%0d_end", idx), 1'b0);
  endtask

  initial begin
    logic found;
    logic bad;

    frames[0] = '{1'b0, 10'h3FF, 16'hA55A, 1'b1, 20'b1101_0010_1010_1011_0100};
    frames[1] = '{1'b0, 10'h000, 16'h1234, 1'b0, 20'hFFFFF};
    frames[2] = '{1'b0, 10'h3FF, 16'h00FF, 1'b1, 20'b1000_0000_0011_1111_1110};
    frames[3] = '{1'b0, 10'h3FF, 16'h8001, 1'b1, 20'b1100_0000_0010_0000_0010};
    frames[4] = '{1'b0, 10'h3FE, 16'h0000, 1'b0, 20'hFFFFF};
    frames[5] = '{1'b1, 10'h3FF, 16'hA55A, 1'b1, 20'b1101_0010_1010_1011_0100};

    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; target = 1'b0;
    tick(2);
    rst = 1'b0;
    check_idle("reset_a", 1'b0);
    target = 1'b1;
    check_idle("reset_b", 1'b0);
    target = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_frame(i, frames[i]);
    end

    // Ten consecutive writes: nine words streamed back-to-back, the tenth dropped.
    target = 1'b0;
    do_reset();
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          push(10'h3FF, 16'(i));
          if (i == 8) begin
            chk("burst_count_peak", cnt_a, 8);
            chk("burst_full", full_a, 1);
            chk("burst_ovf_before", ovf_a, 0);
          end
        end
        chk("burst_count_after_drop", cnt_a, 8);
        chk("burst_full_after_drop", full_a, 1);
        chk("burst_ovf", ovf_a, 1);
      end
      begin
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
          @(negedge clk);
          if (tx_a === 1'b0) found = 1'b1;
        end
        chk("burst_start_seen", found, 1);
        if (found) begin
          for (int n = 0; n < 720; n++) begin
            if (n > 0) @(negedge clk);
            chk($sformatf("burst_w%0d_bit%0d", n / 80, (n / 4) % 20), tx_a,
                frame_bit(16'(n / 80), (n / 4) % 20));
            chk($sformatf("burst_busy_%0d", n), busy_a, 1);
          end
          @(negedge clk);
          check_idle("burst_end", 1'b1);
        end
      end
    join
    do_reset();
    check_idle("burst_reset", 1'b0);

    // STOP-end pop coinciding with a push while three words are queued.
    do_reset();
    push(10'h3FF, 16'h0000);
    push(10'h3FF, 16'h0001);
    push(10'h3FF, 16'h0002);
    push(10'h3FF, 16'h0003);
    tick(77);
    chk("pp_count_before", cnt_a, 3);
    chk("pp_tx_stop", tx_a, 1);
    chk("pp_busy_before", busy_a, 1);
    push(10'h3FF, 16'h0004);
    chk("pp_count_after", cnt_a, 3);
    chk("pp_tx_start", tx_a, 0);
    chk("pp_busy_after", busy_a, 1);
    tick(3);
    chk("pp_start_hold", tx_a, 0);
    tick(1);
    chk("pp_next_word_bit0", tx_a, 1);

    // Reset during high-byte data bit 3 with two words queued; a same-cycle write is ignored.
    do_reset();
    push(10'h3FF, 16'hF7FF);
    push(10'h3FF, 16'h1111);
    push(10'h3FF, 16'h2222);
    tick(56);
    chk("rst_mid_count", cnt_a, 2);
    chk("rst_mid_busy", busy_a, 1);
    chk("rst_mid_bit3", tx_a, 0);
    rst = 1'b1; wr_en = 1'b1; wr_addr = 10'h3FF; wr_data = 16'hBEEF;
    tick(1);
    rst = 1'b0; wr_en = 1'b0;
    check_idle("rst_mid", 1'b0);
    bad = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || busy_a !== 1'b0) bad = 1'b1;
    end
    chk("rst_mid_quiet", bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
